spi_frame_sequencer: RTL and testbench

Frame-level controller for the SPI register-write path. It runs on the synchronized serial clock and tracks each 16-bit SPI frame through its command, address and data phases. Validated write frames are queued in a small command FIFO, and each queued write is handed to the register bank over a valid/ready handshake. Malformed, aborted and dropped frames are counted, and readback is optional.

---
 rtl/spi_frame_pkg.sv | 23 ++
 rtl/spi_cmd_fifo.sv | 77 +++++++
 rtl/spi_frame_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg
// Shared constants and types for the SPI register-write frame path:
//   FRAME_BITS / ADDR_W / DATA_W : frame geometry (1 R/W bit, 7 address, 8 data)
//   state_e                      : frame FSM states
//   wr_cmd_t                     : one queued register-write command
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo
// First-word-fall-through command queue between the frame FSM and the
// register bank.
// Ports:
//   SCLK_sig, nrst : clock, async active-low reset (contents are cleared)
//   push, push_cmd : enqueue; accepted when not full, or when full and popping
//   pop            : dequeue the head; ignored when empty
//   head           : current head entry (valid while !empty)
//   full, empty    : occupancy flags
module spi_cmd_fifo
    import spi_frame_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    SCLK_sig,
    input  logic    nrst,
    input  logic    push,
    input  wr_cmd_t push_cmd,
    input  logic    pop,
    output wr_cmd_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wr_cmd_t          mem_q [DEPTH];
    wr_cmd_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot a full-queue push needs.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_cmd;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge SCLK_sig or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
// Tracks 16-bit SPI frames (MSB first: R/W, 7-bit address, 8-bit data) on the
// synchronized serial clock, queues valid write frames and hands them to the
// register bank over wr_valid/wr_ready. Bad address, full-queue drops and
// aborted frames bump a saturating error counter.
// Ports:
//   SCLK_sig, nrst       : clock, async active-low reset
//   cs_active, mosi      : synchronized chip-select and serial data
//   wr_valid/wr_ready    : head-of-queue handshake, wr_addr/wr_data = head
//   frame_done           : one-cycle pulse after every bit-15 edge
//   busy                 : frame in progress
//   err_cnt              : saturating error count
//   rd_addr/rd_data/miso : readback path, only with SPI_FRAME_READBACK_EN
// Build option: define SPI_FRAME_READBACK_EN to enable serial readback.
//
// state | meaning
// IDLE  | waiting for bit 0 (R/W) of a frame
// ADDR  | shifting in address bits 1..7
// DATA  | shifting in data bits 8..15; bit 15 commits
module spi_frame_sequencer
    import spi_frame_pkg::*;
#(
    parameter int NUM_REGS   = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              SCLK_sig,
    input  logic              nrst,
    input  logic              cs_active,
    input  logic              mosi,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        err_cnt
`ifdef SPI_FRAME_READBACK_EN
    ,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              miso
`endif
);

    localparam logic [3:0] ADDR_LAST_BIT  = 4'(ADDR_W);
    localparam logic [3:0] DATA_FIRST_BIT = 4'(ADDR_W + 1);
    localparam logic [3:0] LAST_BIT       = 4'(FRAME_BITS - 1);

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              err_inc, push, pop, addr_ok;
    logic              fifo_full, fifo_empty;
    wr_cmd_t           push_cmd, head;

    assign addr_ok       = int'(addr_q) < NUM_REGS;
    assign push_cmd.addr = addr_q;
    assign push_cmd.data = {data_q[DATA_W-2:0], mosi};
    assign pop           = !fifo_empty && wr_ready;

`ifdef SPI_FRAME_READBACK_EN
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              rd_ok;

    assign rd_ok   = int'(rd_addr_q) < NUM_REGS;
    assign rd_addr = rd_addr_q;
    assign miso    = sh_q[DATA_W-1];

    // The shifter always drains toward zero, so miso idles low once the
    // last data bit has been presented for its cycle.
    always_comb begin
        rd_addr_d = rd_addr_q;
        sh_d      = {sh_q[DATA_W-2:0], 1'b0};
        if (cs_active && state_q == ADDR && bit_cnt_q == ADDR_LAST_BIT)
            rd_addr_d = {addr_q[ADDR_W-2:0], mosi};
        if (cs_active && state_q == DATA && bit_cnt_q == DATA_FIRST_BIT)
            sh_d = (!rw_q && rd_ok) ? rd_data : '0;
        if (!cs_active && state_q != IDLE)
            sh_d = '0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        err_inc      = 1'b0;
        push         = 1'b0;
        if (!cs_active) begin
            if (state_q != IDLE) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                err_inc   = 1'b1;
            end
        end else begin
            // Wraps 15 -> 0 on the commit edge, ready for a back-to-back frame.
            bit_cnt_d = bit_cnt_q + 4'd1;
            case (state_q)
                IDLE: begin
                    rw_d    = mosi;
                    state_d = ADDR;
                end
                ADDR: begin
                    addr_d = {addr_q[ADDR_W-2:0], mosi};
                    if (bit_cnt_q == ADDR_LAST_BIT) state_d = DATA;
                end
                DATA: begin
                    data_d = {data_q[DATA_W-2:0], mosi};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        if (rw_q) begin
                            if (addr_ok && (!fifo_full || pop)) push = 1'b1;
                            else                                err_inc = 1'b1;
                        end
`ifdef SPI_FRAME_READBACK_EN
                        else if (!addr_ok) begin
                            err_inc = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge SCLK_sig or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= '0;
`ifdef SPI_FRAME_READBACK_EN
            rd_addr_q    <= '0;
            sh_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            err_cnt_q    <= err_cnt_d;
`ifdef SPI_FRAME_READBACK_EN
            rd_addr_q    <= rd_addr_d;
            sh_q         <= sh_d;
`endif
        end
    end

    spi_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SCLK_sig (SCLK_sig),
        .nrst     (nrst),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign wr_valid   = !fifo_empty;
    assign wr_addr    = head.addr;
    assign wr_data    = head.data;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
module tb_spi_frame_sequencer;

    logic       SCLK_sig = 1'b0;
    logic       nrst = 1'b1;
    logic       cs_active = 1'b0;
    logic       mosi = 1'b0;
    logic       wr_ready = 1'b0;
    logic       wr_valid, frame_done, busy;
    logic [6:0] wr_addr;
    logic [7:0] wr_data, err_cnt;
`ifdef SPI_FRAME_READBACK_EN
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       miso;
    assign rd_data = (rd_addr == 7'd4) ? 8'h3C : 8'hEE;
`endif

    int   n_checks = 0;
    int   n_pass = 0;
    logic busy_gap, done_early;

    always #5 SCLK_sig = ~SCLK_sig;

    spi_frame_sequencer #(.NUM_REGS(5), .FIFO_DEPTH(2)) dut (
        .SCLK_sig   (SCLK_sig),
        .nrst       (nrst),
        .cs_active  (cs_active),
        .mosi       (mosi),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .err_cnt    (err_cnt)
`ifdef SPI_FRAME_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .miso       (miso)
`endif
    );

    // Drive one edge's worth of inputs, then return 1 time unit after the edge.
    task automatic edge_bit(input logic cs, input logic b);
        cs_active = cs;
        mosi      = b;
        @(posedge SCLK_sig);
        #1;
    endtask

    // Frame word = {rw, addr[6:0], data[7:0]}, sent MSB first.
    task automatic send_frame(input logic [15:0] f);
        busy_gap   = 1'b0;
        done_early = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            edge_bit(1'b1, f[i]);
            if (i != 0) begin
                if (busy !== 1'b1) busy_gap = 1'b1;
                if (frame_done !== 1'b0) done_early = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        cs_active = 1'b0;
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        #2 nrst = 1'b0;
        #1;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL rst_wr_valid: got %b want 0", wr_valid); else n_pass++;
        n_checks++; if (wr_addr !== 7'd0) $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'd0) $display("FAIL rst_wr_data: got %h want 00", wr_data); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else n_pass++;
`ifdef SPI_FRAME_READBACK_EN
        n_checks++; if (miso !== 1'b0) $display("FAIL rst_miso: got %b want 0", miso); else n_pass++;
        n_checks++; if (rd_addr !== 7'd0) $display("FAIL rst_rd_addr: got %0d want 0", rd_addr); else n_pass++;
`endif
        @(posedge SCLK_sig); #1;
        nrst = 1'b1;
    endtask

    task automatic test_single_write();
        wr_ready = 1'b1;
        send_frame({1'b1, 7'd2, 8'hA5});
        n_checks++; if (busy_gap !== 1'b0) $display("FAIL sw_busy_during: got gap %b want 0", busy_gap); else n_pass++;
        n_checks++; if (done_early !== 1'b0) $display("FAIL sw_done_early: got %b want 0", done_early); else n_pass++;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL sw_frame_done: got %b want 1", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL sw_busy_after: got %b want 0", busy); else n_pass++;
        n_checks++; if (wr_valid !== 1'b1) $display("FAIL sw_wr_valid: got %b want 1", wr_valid); else n_pass++;
        n_checks++; if (wr_addr !== 7'd2) $display("FAIL sw_wr_addr: got %0d want 2", wr_addr); else n_pass++;
        n_checks++; if (wr_data !== 8'hA5) $display("FAIL sw_wr_data: got %h want a5", wr_data); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL sw_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL sw_valid_pulse: got %b want 0", wr_valid); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL sw_done_pulse: got %b want 0", frame_done); else n_pass++;
        wr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        wr_ready = 1'b0;
        send_frame({1'b1, 7'd3, 8'h11});
        send_frame({1'b1, 7'd1, 8'h22});
        n_checks++; if (wr_addr !== 7'd3 || wr_data !== 8'h11) $display("FAIL b2b_stall_hold: got %0d/%h want 3/11", wr_addr, wr_data); else n_pass++;
        send_frame({1'b1, 7'd0, 8'h33});
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL b2b_drop_err: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (frame_done !== 1'b1) $display("FAIL b2b_done3: got %b want 1", frame_done); else n_pass++;
        wr_ready = 1'b1;
        n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 7'd3 || wr_data !== 8'h11) $display("FAIL b2b_head1: got %b %0d/%h want 1 3/11", wr_valid, wr_addr, wr_data); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 7'd1 || wr_data !== 8'h22) $display("FAIL b2b_head2: got %b %0d/%h want 1 1/22", wr_valid, wr_addr, wr_data); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", wr_valid); else n_pass++;
        wr_ready = 1'b0;
    endtask

    task automatic test_read_frame();
`ifdef SPI_FRAME_READBACK_EN
        logic [7:0] exp_bits;
        logic       exp_miso;
        exp_bits = 8'h3C;
        for (int i = 15; i >= 0; i--) begin
            edge_bit(1'b1, (i == 15) ? 1'b0 : ((i >= 8) ? (i == 10) : 1'b0));
            exp_miso = (i <= 7) ? exp_bits[i] : 1'b0;
            n_checks++; if (miso !== exp_miso) $display("FAIL rb_miso_edge%0d: got %b want %b", 15 - i, miso, exp_miso); else n_pass++;
        end
        n_checks++; if (rd_addr !== 7'd4) $display("FAIL rb_rd_addr: got %0d want 4", rd_addr); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL rb_no_push: got %b want 0", wr_valid); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL rb_err_ok: got %0d want 1", err_cnt); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (miso !== 1'b0) $display("FAIL rb_miso_idle: got %b want 0", miso); else n_pass++;
        send_frame({1'b0, 7'd6, 8'h00});
        n_checks++; if (err_cnt !== 8'd2) $display("FAIL rb_bad_addr_err: got %0d want 2", err_cnt); else n_pass++;
        edge_bit(1'b0, 1'b0);
`else
        send_frame({1'b0, 7'd2, 8'h99});
        n_checks++; if (frame_done !== 1'b1) $display("FAIL rd_done: got %b want 1", frame_done); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL rd_no_push: got %b want 0", wr_valid); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL rd_no_err: got %0d want 1", err_cnt); else n_pass++;
        edge_bit(1'b0, 1'b0);
`endif
    endtask

    task automatic test_full_pop_same_edge();
        logic [15:0] f3;
        do_reset();
        wr_ready = 1'b0;
        send_frame({1'b1, 7'd0, 8'h01});
        send_frame({1'b1, 7'd4, 8'h02});
        f3 = {1'b1, 7'd2, 8'h03};
        for (int i = 15; i >= 1; i--) edge_bit(1'b1, f3[i]);
        wr_ready = 1'b1;
        edge_bit(1'b1, f3[0]);
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL fp_no_err: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 7'd4 || wr_data !== 8'h02) $display("FAIL fp_head2: got %b %0d/%h want 1 4/02", wr_valid, wr_addr, wr_data); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 7'd2 || wr_data !== 8'h03) $display("FAIL fp_head3: got %b %0d/%h want 1 2/03", wr_valid, wr_addr, wr_data); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL fp_occupancy: got %b want 0", wr_valid); else n_pass++;
        wr_ready = 1'b0;
    endtask

    task automatic test_bad_addr_abort();
        logic [15:0] fa;
        do_reset();
        wr_ready = 1'b1;
        send_frame({1'b1, 7'd7, 8'h55});
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL ba_err: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL ba_no_push: got %b want 0", wr_valid); else n_pass++;
        fa = {1'b1, 7'd1, 8'h66};
        for (int i = 15; i >= 6; i--) edge_bit(1'b1, fa[i]);
        n_checks++; if (busy !== 1'b1) $display("FAIL ab_busy_before: got %b want 1", busy); else n_pass++;
        edge_bit(1'b0, 1'b0);
        n_checks++; if (err_cnt !== 8'd2) $display("FAIL ab_err: got %0d want 2", err_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL ab_idle: got busy %b done %b want 0 0", busy, frame_done); else n_pass++;
        wr_ready = 1'b0;
        send_frame({1'b1, 7'd3, 8'h77});
        n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 7'd3 || wr_data !== 8'h77) $display("FAIL ab_next_frame: got %b %0d/%h want 1 3/77", wr_valid, wr_addr, wr_data); else n_pass++;
        n_checks++; if (err_cnt !== 8'd2) $display("FAIL ab_err_hold: got %0d want 2", err_cnt); else n_pass++;
        wr_ready = 1'b1;
        edge_bit(1'b0, 1'b0);
        wr_ready = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            edge_bit(1'b1, 1'b1);
            edge_bit(1'b0, 1'b0);
            if (i == 253) begin
                n_checks++; if (err_cnt !== 8'd254) $display("FAIL sat_254: got %0d want 254", err_cnt); else n_pass++;
            end
        end
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] fp;
        wr_ready = 1'b0;
        send_frame({1'b1, 7'd1, 8'h5A});
        fp = {1'b1, 7'd2, 8'h11};
        for (int i = 15; i >= 11; i--) edge_bit(1'b1, fp[i]);
        nrst = 1'b0;
        #1;
        n_checks++; if (wr_valid !== 1'b0 || wr_addr !== 7'd0 || wr_data !== 8'd0) $display("FAIL rm_fifo: got %b %0d/%h want 0 0/00", wr_valid, wr_addr, wr_data); else n_pass++;
        n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL rm_fsm: got busy %b done %b want 0 0", busy, frame_done); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL rm_err: got %0d want 0", err_cnt); else n_pass++;
        #1 nrst = 1'b1;
        send_frame({1'b1, 7'd4, 8'hC3});
        n_checks++; if (wr_valid !== 1'b1 || wr_addr !== 7'd4 || wr_data !== 8'hC3) $display("FAIL rm_next: got %b %0d/%h want 1 4/c3", wr_valid, wr_addr, wr_data); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL rm_next_err: got %0d want 0", err_cnt); else n_pass++;
        edge_bit(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_frame();
        test_full_pop_same_edge();
        test_bad_addr_abort();
        test_saturate();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
